// File: rtl/tl_flow_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tl_flow_pkg
//  Purpose  : Shared state encodings for the transaction-layer flow-control FSM.
//  Revision : 1.0  initial release
// ============================================================================

package tl_flow_pkg;

    localparam int ST_W = 5;

    localparam logic [ST_W-1:0] ST_RESET  = 5'b00001;
    localparam logic [ST_W-1:0] ST_INIT   = 5'b00010;
    localparam logic [ST_W-1:0] ST_IDLE   = 5'b00100;
    localparam logic [ST_W-1:0] ST_ACTIVE = 5'b01000;
    localparam logic [ST_W-1:0] ST_ERROR  = 5'b10000;

endpackage

`default_nettype wire

// File: rtl/tl_pause_hyst.sv
`default_nettype none
// ============================================================================
//  Module   : tl_pause_hyst
//  Purpose  : One-channel pause flop with high/low watermark hysteresis.
//  Revision : 1.0  initial release
// ============================================================================

module tl_pause_hyst #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] count_i,
    input  logic [CNT_W-1:0] hi_i,
    input  logic [CNT_W-1:0] lo_i,
    output logic             pause_o
);

    logic pause_q;
    logic pause_d;

    // Set wins over clear; only reachable with an invalid config, which traps to ERROR anyway.
    always_comb begin
        pause_d = pause_q;
        if (clr_i) begin
            pause_d = 1'b0;
        end else if (en_i) begin
            if (count_i >= hi_i) begin
                pause_d = 1'b1;
            end else if (count_i <= lo_i) begin
                pause_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pause_q <= 1'b0;
        end else begin
            pause_q <= pause_d;
        end
    end

    assign pause_o = pause_q;

endmodule

`default_nettype wire

// File: rtl/tl_flow_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tl_flow_ctrl_fsm
//  Purpose  : VC flow-control FSM: watermark latch, link-activity tracking,
//             per-channel pause hysteresis and sticky fault trapping.
//             Optional active-cycle counter enabled by TL_FLOW_ACT_CNT_EN.
//  Revision : 1.0  initial release
// ============================================================================

module tl_flow_ctrl_fsm
    import tl_flow_pkg::*;
#(
    parameter int NUM_CH    = 8,
    parameter int CNT_W     = 4,
    parameter int THR_W     = 3,
    parameter int ACT_CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    init,
    input  logic [THR_W-1:0]        umbral_alto,
    input  logic [THR_W-1:0]        umbral_bajo,
    input  logic [NUM_CH-1:0]       empties,
    input  logic [NUM_CH*CNT_W-1:0] fifo_count,
    input  logic [NUM_CH-1:0]       overflow,
    output logic [THR_W-1:0]        umbral_superior,
    output logic [THR_W-1:0]        umbral_inferior,
    output logic [ST_W-1:0]         state,
    output logic [NUM_CH-1:0]       pause,
    output logic [NUM_CH-1:0]       err_ch,
    output logic                    cfg_err,
    output logic [ACT_CNT_W-1:0]    active_cycles
);

    logic [ST_W-1:0]   state_q;
    logic [ST_W-1:0]   state_d;
    logic [THR_W-1:0]  hi_q;
    logic [THR_W-1:0]  lo_q;
    logic [NUM_CH-1:0] err_ch_q;
    logic [NUM_CH-1:0] err_ch_d;
    logic              cfg_err_q;
    logic              cfg_err_d;
    logic [NUM_CH-1:0] pause_q;

    logic              w_run;
    logic              w_in_err;
    logic              w_in_active;
    logic              w_bad_cfg;
    logic [CNT_W-1:0]  w_hi_ext;
    logic [CNT_W-1:0]  w_lo_ext;

    assign w_bad_cfg = (lo_q >= hi_q);
    assign w_hi_ext  = CNT_W'(hi_q);
    assign w_lo_ext  = CNT_W'(lo_q);

    // ------------------------------------------------------------------ state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------ next state
    always_comb begin
        state_d = state_q;
        if (init) begin
            state_d = ST_INIT;
        end else begin
            case (state_q)
                ST_RESET:  state_d = ST_RESET;
                ST_INIT:   state_d = w_bad_cfg ? ST_ERROR : ST_IDLE;
                ST_IDLE: begin
                    if (|overflow) begin
                        state_d = ST_ERROR;
                    end else if (empties != {NUM_CH{1'b1}}) begin
                        state_d = ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (|overflow) begin
                        state_d = ST_ERROR;
                    end else if (empties == {NUM_CH{1'b1}}) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ERROR:  state_d = ST_ERROR;
                default:   state_d = ST_RESET;
            endcase
        end
    end

    // ------------------------------------------------------------------ output / datapath decode
    always_comb begin
        w_run       = (state_q == ST_IDLE) || (state_q == ST_ACTIVE);
        w_in_err    = (state_q == ST_ERROR);
        w_in_active = (state_q == ST_ACTIVE);

        err_ch_d = err_ch_q;
        if (init) begin
            err_ch_d = '0;
        end else if (w_run) begin
            err_ch_d = err_ch_q | overflow;
        end

        cfg_err_d = cfg_err_q;
        if (init) begin
            cfg_err_d = 1'b0;
        end else if ((state_q == ST_INIT) && w_bad_cfg) begin
            cfg_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q      <= '0;
            lo_q      <= '0;
            err_ch_q  <= '0;
            cfg_err_q <= 1'b0;
        end else begin
            if (init) begin
                hi_q <= umbral_alto;
                lo_q <= umbral_bajo;
            end
            err_ch_q  <= err_ch_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // ------------------------------------------------------------------ per-channel pause
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tl_pause_hyst #(
            .CNT_W (CNT_W)
        ) u_hyst (
            .clk     (clk),
            .reset   (reset),
            .clr_i   (init),
            .en_i    (w_run),
            .count_i (fifo_count[i*CNT_W +: CNT_W]),
            .hi_i    (w_hi_ext),
            .lo_i    (w_lo_ext),
            .pause_o (pause_q[i])
        );
    end

    // ------------------------------------------------------------------ optional activity counter
`ifdef TL_FLOW_ACT_CNT_EN
    logic [ACT_CNT_W-1:0] act_q;

    always_ff @(posedge clk) begin
        if (reset || init) begin
            act_q <= '0;
        end else if (w_in_active && (act_q != {ACT_CNT_W{1'b1}})) begin
            act_q <= act_q + ACT_CNT_W'(1);
        end
    end

    assign active_cycles = act_q;
`else
    assign active_cycles = '0;
`endif

    assign state           = state_q;
    assign umbral_superior = hi_q;
    assign umbral_inferior = lo_q;
    assign err_ch          = err_ch_q;
    assign cfg_err         = cfg_err_q;
    assign pause           = w_in_err ? {NUM_CH{1'b1}} : (w_run ? pause_q : '0);

endmodule

`default_nettype wire

// File: tb/tb_tl_flow_ctrl_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_tl_flow_ctrl_fsm
//  Purpose  : Scoreboard bench for tl_flow_ctrl_fsm (directed vectors).
//  Revision : 1.0  initial release
// ============================================================================

module tb_tl_flow_ctrl_fsm;

    localparam logic [4:0] S_RST = 5'b00001;
    localparam logic [4:0] S_INI = 5'b00010;
    localparam logic [4:0] S_IDL = 5'b00100;
    localparam logic [4:0] S_ACT = 5'b01000;
    localparam logic [4:0] S_ERR = 5'b10000;

`ifdef TL_FLOW_ACT_CNT_EN
    localparam int LONG_RUN = 70000;
`else
    localparam int LONG_RUN = 20;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        init;
    logic [2:0]  umbral_alto;
    logic [2:0]  umbral_bajo;
    logic [7:0]  empties;
    logic [31:0] fifo_count;
    logic [7:0]  overflow;
    logic [2:0]  umbral_superior;
    logic [2:0]  umbral_inferior;
    logic [4:0]  state;
    logic [7:0]  pause;
    logic [7:0]  err_ch;
    logic        cfg_err;
    logic [15:0] active_cycles;

    always #5 clk = ~clk;

    tl_flow_ctrl_fsm #(
        .NUM_CH    (8),
        .CNT_W     (4),
        .THR_W     (3),
        .ACT_CNT_W (16)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .init            (init),
        .umbral_alto     (umbral_alto),
        .umbral_bajo     (umbral_bajo),
        .empties         (empties),
        .fifo_count      (fifo_count),
        .overflow        (overflow),
        .umbral_superior (umbral_superior),
        .umbral_inferior (umbral_inferior),
        .state           (state),
        .pause           (pause),
        .err_ch          (err_ch),
        .cfg_err         (cfg_err),
        .active_cycles   (active_cycles)
    );

    typedef struct {
        bit          chk;
        logic [4:0]  st;
        logic [7:0]  pa;
        logic [7:0]  er;
        logic        cf;
        logic [2:0]  hi;
        logic [2:0]  lo;
        logic [15:0] act;
    } exp_t;

    exp_t        sb[$];
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [2:0]  hi_m = '0;
    logic [2:0]  lo_m = '0;
    logic [15:0] act_m = '0;
    logic [4:0]  prev_st = S_RST;

    task automatic cmp(input string name, input logic [15:0] got, input logic [15:0] want);
        n_cmp++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: each entry describes the outputs right after the next active edge.
    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.chk) begin
                    cmp("state",   16'(state),           16'(e.st));
                    cmp("pause",   16'(pause),           16'(e.pa));
                    cmp("err_ch",  16'(err_ch),          16'(e.er));
                    cmp("cfg_err", 16'(cfg_err),         16'(e.cf));
                    cmp("u_sup",   16'(umbral_superior), 16'(e.hi));
                    cmp("u_inf",   16'(umbral_inferior), 16'(e.lo));
                    cmp("act_cyc", active_cycles,        e.act);
                end
            end
        end
    end

    // Push the expectation for the edge that follows the currently driven inputs.
    task automatic step(input bit c, input logic [4:0] st, input logic [7:0] pa,
                        input logic [7:0] er, input logic cf);
        exp_t e;
        if (reset) begin
            hi_m = '0;
            lo_m = '0;
        end else if (init) begin
            hi_m = umbral_alto;
            lo_m = umbral_bajo;
        end
`ifdef TL_FLOW_ACT_CNT_EN
        if (reset || init) begin
            act_m = '0;
        end else if ((prev_st == S_ACT) && (act_m != 16'hFFFF)) begin
            act_m = act_m + 16'd1;
        end
`endif
        prev_st = reset ? S_RST : st;
        e.chk = c; e.st = st; e.pa = pa; e.er = er; e.cf = cf;
        e.hi = hi_m; e.lo = lo_m; e.act = act_m;
        sb.push_back(e);
        @(negedge clk);
    endtask

    task automatic set_cnt(input int ch, input logic [3:0] v);
        fifo_count[ch*4 +: 4] = v;
    endtask

    initial begin : stim
        reset = 1'b1; init = 1'b0; umbral_alto = '0; umbral_bajo = '0;
        empties = 8'hFF; fifo_count = '0; overflow = '0;
        @(negedge clk);

        repeat (3) step(1, S_RST, 8'h00, 8'h00, 1'b0);
        reset = 1'b0; umbral_alto = 3'd5; umbral_bajo = 3'd1;
        repeat (5) step(1, S_RST, 8'h00, 8'h00, 1'b0);

        init = 1'b1; umbral_alto = 3'd6; umbral_bajo = 3'd2;
        step(1, S_INI, 8'h00, 8'h00, 1'b0);
        init = 1'b0; umbral_alto = 3'd1; umbral_bajo = 3'd7;
        step(1, S_IDL, 8'h00, 8'h00, 1'b0);

        empties = 8'hFE; step(1, S_ACT, 8'h00, 8'h00, 1'b0);
        empties = 8'hFF; step(1, S_IDL, 8'h00, 8'h00, 1'b0);

        empties = 8'hF7;
        set_cnt(3, 4'd5); step(1, S_ACT, 8'h00, 8'h00, 1'b0);
        set_cnt(3, 4'd6); step(1, S_ACT, 8'h08, 8'h00, 1'b0);
        set_cnt(3, 4'd4); step(1, S_ACT, 8'h08, 8'h00, 1'b0);
        set_cnt(3, 4'd3); step(1, S_ACT, 8'h08, 8'h00, 1'b0);
        set_cnt(3, 4'd2); step(1, S_ACT, 8'h00, 8'h00, 1'b0);
        set_cnt(0, 4'd8); step(1, S_ACT, 8'h01, 8'h00, 1'b0);
        set_cnt(0, 4'd3); step(1, S_ACT, 8'h01, 8'h00, 1'b0);
        set_cnt(0, 4'd2); step(1, S_ACT, 8'h00, 8'h00, 1'b0);
        fifo_count = '0;

        // Overflow beats the all-empty return to IDLE.
        overflow = 8'h10; empties = 8'hFF; step(1, S_ERR, 8'hFF, 8'h10, 1'b0);
        overflow = 8'h01; empties = 8'hFE; step(1, S_ERR, 8'hFF, 8'h10, 1'b0);
        overflow = 8'h00;
        repeat (2) step(1, S_ERR, 8'hFF, 8'h10, 1'b0);

        init = 1'b1; umbral_alto = 3'd2; umbral_bajo = 3'd2;
        step(1, S_INI, 8'h00, 8'h00, 1'b0);
        init = 1'b0;
        repeat (2) step(1, S_ERR, 8'hFF, 8'h00, 1'b1);

        init = 1'b1; umbral_alto = 3'd6; umbral_bajo = 3'd2;
        step(1, S_INI, 8'h00, 8'h00, 1'b0);
        init = 1'b0; empties = 8'hFF;
        step(1, S_IDL, 8'h00, 8'h00, 1'b0);
        overflow = 8'h01; step(1, S_ERR, 8'hFF, 8'h01, 1'b0);
        overflow = 8'h00;

        init = 1'b1; step(1, S_INI, 8'h00, 8'h00, 1'b0);
        init = 1'b0; step(1, S_IDL, 8'h00, 8'h00, 1'b0);
        empties = 8'hFE;
        for (int k = 0; k < LONG_RUN; k++) step(0, S_ACT, 8'h00, 8'h00, 1'b0);
        step(1, S_ACT, 8'h00, 8'h00, 1'b0);
        reset = 1'b1; step(1, S_RST, 8'h00, 8'h00, 1'b0);
        reset = 1'b0; step(1, S_RST, 8'h00, 8'h00, 1'b0);

        repeat (3) @(negedge clk);
        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
